uart_word_assembler: RTL and testbench



---
 rtl/uart_word_assembler.sv | 126 ++++++++++++
 tb/tb_uart_word_assembler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_word_assembler.sv
// rtl/uart_word_assembler.sv - UART byte pairs to 16-bit big-endian words via show-ahead FIFO.
// Optional inter-byte timeout compiled in with UART_ASM_TIMEOUT_EN.
module uart_word_assembler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BYTE_TIMEOUT = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_done,
  input  logic [7:0]                  rx_data,
  input  logic                        word_ready,
  output logic                        word_valid,
  output logic [15:0]                 word_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        timeout_err,
  input  logic                        err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {WAIT_HI, WAIT_LO} state_t;

  state_t        state_q;
  logic          rx_done_q;
  logic [7:0]    hi_q;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  logic accept;
  logic pop;
  logic push_req;
  logic push_ok;
  logic to_fire;

  assign accept   = rx_done && !rx_done_q;
  assign pop      = (count_q != '0) && word_ready;
  assign push_req = (state_q == WAIT_LO) && accept;
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign push_ok  = push_req && ((count_q < DEPTH_C) || pop);

`ifdef UART_ASM_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(BYTE_TIMEOUT - 1);
  logic [15:0] cnt_q;
  logic        timeout_err_q;
  assign to_fire     = (state_q == WAIT_LO) && !accept && (cnt_q == TO_LAST);
  assign timeout_err = timeout_err_q;
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WAIT_HI;
      rx_done_q  <= 1'b0;
      hi_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef UART_ASM_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      rx_done_q <= rx_done;

      case (state_q)
        WAIT_HI: begin
          if (accept) begin
            hi_q    <= rx_data;
            state_q <= WAIT_LO;
`ifdef UART_ASM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        WAIT_LO: begin
          if (accept || to_fire) begin
            state_q <= WAIT_HI;
          end
`ifdef UART_ASM_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        default: state_q <= WAIT_HI;
      endcase

      if (push_ok) begin
        mem_q[wr_ptr_q] <= {hi_q, rx_data};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push_ok && pop) begin
        count_q <= count_q - 1'b1;
      end

      // An error event on the same edge as err_clr keeps the flag set.
      overflow_q <= (push_req && !push_ok) || (overflow_q && !err_clr);
`ifdef UART_ASM_TIMEOUT_EN
      timeout_err_q <= to_fire || (timeout_err_q && !err_clr);
`endif
    end
  end

  assign word_valid = (count_q != '0);
  assign word_data  = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// tb/tb_uart_word_assembler.sv - scoreboard bench for uart_word_assembler (DEPTH 4, timeout 100).
// Timeout cases are exercised when UART_ASM_TIMEOUT_EN is defined.
module tb_uart_word_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        word_ready = 1'b0;
  logic        word_valid;
  logic [15:0] word_data;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  uart_word_assembler #(.FIFO_DEPTH(4), .BYTE_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .word_ready(word_ready), .word_valid(word_valid), .word_data(word_data),
    .fifo_count(fifo_count), .overflow(overflow), .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Words leaving the FIFO are matched against the queue in issue order.
  always @(negedge clk) begin
    if (rst && word_valid && word_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got 0x%0h, expected none", word_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (word_data !== e) begin
          n_err++;
          $display("FAIL word_order: got 0x%0h, expected 0x%0h", word_data, e);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input logic pp, input logic clr);
    @(posedge clk); #1;
    rx_done = 1'b1;
    rx_data = b;
    if (pp) word_ready = 1'b1;
    if (clr) err_clr = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    rx_done = 1'b0;
    if (pp) word_ready = 1'b0;
    if (clr) err_clr = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic expect_push);
    send_byte(w[15:8], 1, 1'b0, 1'b0);
    if (expect_push) exp_q.push_back(w);
    send_byte(w[7:0], 1, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    @(posedge clk); #1;
    word_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    word_ready = 1'b0;
  endtask

  task automatic clear_errors();
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    #2;
    check("reset_valid", 32'(word_valid), 32'h0);
    check("reset_data", 32'(word_data), 32'h0);
    check("reset_count", 32'(fifo_count), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);
    check("reset_timeout", 32'(timeout_err), 32'h0);
    #20 rst = 1'b1;

    send_word(16'h1234, 1'b1);
    check("first_valid", 32'(word_valid), 32'h1);
    check("first_data", 32'(word_data), 32'h1234);
    check("first_count", 32'(fifo_count), 32'h1);
    @(posedge clk); #1;
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    check("first_popped_count", 32'(fifo_count), 32'h0);

    send_byte(8'hAB, 5, 1'b0, 1'b0);
    exp_q.push_back(16'hABCD);
    send_byte(8'hCD, 1, 1'b0, 1'b0);
    check("held_strobe_count", 32'(fifo_count), 32'h1);
    drain(1);
    check("held_strobe_drained", 32'(fifo_count), 32'h0);

    send_word(16'h1111, 1'b1);
    send_word(16'h2222, 1'b1);
    send_word(16'h3333, 1'b1);
    send_word(16'h4444, 1'b1);
    check("full_no_overflow", 32'(overflow), 32'h0);
    send_word(16'h5555, 1'b0);
    check("overflow_count", 32'(fifo_count), 32'h4);
    check("overflow_set", 32'(overflow), 32'h1);
    send_byte(8'h66, 1, 1'b0, 1'b0);
    send_byte(8'h66, 1, 1'b0, 1'b1);
    check("overflow_beats_clr", 32'(overflow), 32'h1);
    drain(4);
    check("overflow_drained", 32'(fifo_count), 32'h0);
    clear_errors();
    check("overflow_cleared", 32'(overflow), 32'h0);

    send_word(16'hA0A0, 1'b1);
    send_word(16'hA1A1, 1'b1);
    send_word(16'hA2A2, 1'b1);
    send_word(16'hA3A3, 1'b1);
    send_byte(8'hA4, 1, 1'b0, 1'b0);
    exp_q.push_back(16'hA4A4);
    send_byte(8'hA4, 1, 1'b1, 1'b0);
    check("pushpop_count", 32'(fifo_count), 32'h4);
    check("pushpop_overflow", 32'(overflow), 32'h0);
    check("pushpop_head", 32'(word_data), 32'hA1A1);
    drain(4);
    check("pushpop_drained", 32'(fifo_count), 32'h0);

`ifdef UART_ASM_TIMEOUT_EN
    send_byte(8'h55, 1, 1'b0, 1'b0);
    repeat (99) @(posedge clk);
    #1;
    check("timeout_not_yet", 32'(timeout_err), 32'h0);
    @(posedge clk); #1;
    check("timeout_fired", 32'(timeout_err), 32'h1);
    check("timeout_no_word", 32'(fifo_count), 32'h0);
    clear_errors();
    check("timeout_cleared", 32'(timeout_err), 32'h0);
    send_word(16'h0102, 1'b1);
    check("after_timeout_count", 32'(fifo_count), 32'h1);
    send_byte(8'h77, 1, 1'b0, 1'b0);
    repeat (98) @(posedge clk);
    exp_q.push_back(16'h7788);
    send_byte(8'h88, 1, 1'b0, 1'b0);
    check("byte_beats_timeout_err", 32'(timeout_err), 32'h0);
    check("byte_beats_timeout_count", 32'(fifo_count), 32'h2);
    drain(2);
`else
    send_byte(8'h55, 1, 1'b0, 1'b0);
    repeat (200) @(posedge clk);
    exp_q.push_back(16'h5566);
    send_byte(8'h66, 1, 1'b0, 1'b0);
    check("no_timeout_err", 32'(timeout_err), 32'h0);
    check("no_timeout_count", 32'(fifo_count), 32'h1);
    drain(1);
`endif
    check("pre_reset_count", 32'(fifo_count), 32'h0);

    send_word(16'h4242, 1'b0);
    send_byte(8'hEE, 1, 1'b0, 1'b0);
    #3 rst = 1'b0;
    #1;
    check("async_valid", 32'(word_valid), 32'h0);
    check("async_data", 32'(word_data), 32'h0);
    check("async_count", 32'(fifo_count), 32'h0);
    check("async_overflow", 32'(overflow), 32'h0);
    check("async_timeout", 32'(timeout_err), 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    send_word(16'h9ABC, 1'b1);
    check("post_reset_count", 32'(fifo_count), 32'h1);
    check("post_reset_data", 32'(word_data), 32'h9ABC);
    drain(1);
    check("post_reset_drained", 32'(fifo_count), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
